// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: dummy read, three stack pushes, two-byte vector fetch, PC load.
// Optional INTERRUPT_HIJACK_EN lets a late NMI redirect an IRQ sequence before the vector fetch.
module interrupt_sequencer (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enableFFs,
  input  logic        pendingInterrupt,
  input  logic        resetDetected,
  input  logic        nmiGenerated,
  input  logic        irqGenerated,
  input  logic        instructionBoundary,
  input  logic [15:0] pcIn,
  input  logic [7:0]  spIn,
  input  logic [7:0]  statusIn,
  input  logic [7:0]  dataIn,
  output logic [15:0] addressOut,
  output logic [7:0]  dataOut,
  output logic        writeEn,
  output logic        spDecrement,
  output logic        setIFlag,
  output logic        interruptStarted,
  output logic        pcLoad,
  output logic [15:0] pcLoadValue,
  output logic        busy,
  output logic [2:0]  debugState
);

  typedef enum logic [2:0] {
    IDLE, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD
  } state_t;

  typedef enum logic [1:0] {SRC_IRQ, SRC_NMI, SRC_RST} src_t;

`ifdef INTERRUPT_HIJACK_EN
  localparam logic hijackEn = 1'b1;
`else
  localparam logic hijackEn = 1'b0;
`endif

  state_t      state;
  src_t        src;
  logic [7:0]  lowByte;
  logic [7:0]  highByte;
  logic [15:0] vecBase;
  logic        pushState;

  // IRQ is the fallback source, so its flag never changes the outcome.
  logic unusedIrq;
  assign unusedIrq = irqGenerated;

  assign pushState = (state == PUSH_PCH) || (state == PUSH_PCL) || (state == PUSH_P);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      src      <= SRC_IRQ;
      lowByte  <= 8'h00;
      highByte <= 8'h00;
    end else if (enableFFs) begin
      case (state)
        IDLE: begin
          if (pendingInterrupt && instructionBoundary) begin
            state <= DUMMY;
            src   <= resetDetected ? SRC_RST : (nmiGenerated ? SRC_NMI : SRC_IRQ);
          end
        end
        DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P: begin
          case (state)
            DUMMY:    state <= PUSH_PCH;
            PUSH_PCH: state <= PUSH_PCL;
            PUSH_PCL: state <= PUSH_P;
            default:  state <= VEC_LO;
          endcase
          if (hijackEn && (src == SRC_IRQ) && nmiGenerated) src <= SRC_NMI;
        end
        VEC_LO: begin
          lowByte <= dataIn;
          state   <= VEC_HI;
        end
        VEC_HI: begin
          highByte <= dataIn;
          state    <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (src)
      SRC_RST: vecBase = 16'hFFFC;
      SRC_NMI: vecBase = 16'hFFFA;
      default: vecBase = 16'hFFFE;
    endcase
  end

  // Outputs decode the registered state; strobes are gated so a frozen cycle never repeats one.
  always_comb begin
    addressOut       = 16'h0000;
    dataOut          = 8'h00;
    writeEn          = 1'b0;
    spDecrement      = 1'b0;
    setIFlag         = 1'b0;
    interruptStarted = 1'b0;
    pcLoad           = 1'b0;
    case (state)
      DUMMY:    addressOut = pcIn;
      PUSH_PCH: begin
        addressOut = {8'h01, spIn};
        dataOut    = pcIn[15:8];
      end
      PUSH_PCL: begin
        addressOut = {8'h01, spIn};
        dataOut    = pcIn[7:0];
      end
      PUSH_P: begin
        addressOut = {8'h01, spIn};
        dataOut    = {statusIn[7:6], 2'b10, statusIn[3:0]};
      end
      VEC_LO: begin
        addressOut       = vecBase;
        setIFlag         = enableFFs;
        interruptStarted = enableFFs;
      end
      VEC_HI:   addressOut = {vecBase[15:1], 1'b1};
      LOAD:     pcLoad = enableFFs;
      default:  addressOut = 16'h0000;
    endcase
    if (pushState) begin
      spDecrement = enableFFs;
      writeEn     = enableFFs && (src != SRC_RST);
    end
  end

  assign pcLoadValue = {highByte, lowByte};
  assign busy        = (state != IDLE);
  assign debugState  = state;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: vector table plus hand sequences for
// clock-enable gating, NMI hijack and mid-sequence reset.
module tb_interrupt_sequencer;

  logic        clk;
  logic        nrst;
  logic        enableFFs, pendingInterrupt, resetDetected, nmiGenerated, irqGenerated;
  logic        instructionBoundary;
  logic [15:0] pcIn;
  logic [7:0]  spIn, statusIn, dataIn;
  logic [15:0] addressOut, pcLoadValue;
  logic [7:0]  dataOut;
  logic        writeEn, spDecrement, setIFlag, interruptStarted, pcLoad, busy;
  logic [2:0]  debugState;

  interrupt_sequencer dut (
    .clk(clk), .nrst(nrst), .enableFFs(enableFFs), .pendingInterrupt(pendingInterrupt),
    .resetDetected(resetDetected), .nmiGenerated(nmiGenerated), .irqGenerated(irqGenerated),
    .instructionBoundary(instructionBoundary), .pcIn(pcIn), .spIn(spIn), .statusIn(statusIn),
    .dataIn(dataIn), .addressOut(addressOut), .dataOut(dataOut), .writeEn(writeEn),
    .spDecrement(spDecrement), .setIFlag(setIFlag), .interruptStarted(interruptStarted),
    .pcLoad(pcLoad), .pcLoadValue(pcLoadValue), .busy(busy), .debugState(debugState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  flags;   // {en, pending, resetDet, nmi, irq, boundary}
    logic [7:0]  din;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic [7:0]  st;
    logic [15:0] eAddr;
    logic [7:0]  eDout;
    logic [4:0]  eStr;    // {writeEn, spDecrement, setIFlag, interruptStarted, pcLoad}
    logic [15:0] ePcv;
    logic        eBusy;
  } vec_t;

  vec_t vecs[$];
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [5:0] flags, input logic [7:0] din, input logic [15:0] pc,
                        input logic [7:0] sp, input logic [7:0] st, input logic [15:0] eAddr,
                        input logic [7:0] eDout, input logic [4:0] eStr, input logic [15:0] ePcv,
                        input logic eBusy);
    vec_t r;
    r.flags = flags; r.din = din; r.pc = pc; r.sp = sp; r.st = st;
    r.eAddr = eAddr; r.eDout = eDout; r.eStr = eStr; r.ePcv = ePcv; r.eBusy = eBusy;
    vecs.push_back(r);
  endtask

  function automatic logic [7:0] memRd(input logic [15:0] a);
    case (a)
      16'hFFFA: memRd = 8'h34;
      16'hFFFB: memRd = 8'h12;
      16'hFFFD: memRd = 8'hE0;
      16'hFFFF: memRd = 8'h80;
      default:  memRd = 8'h00;
    endcase
  endfunction

  function automatic logic [4:0] strobes();
    strobes = {writeEn, spDecrement, setIFlag, interruptStarted, pcLoad};
  endfunction

  // driver: inputs change on the falling edge, outputs sampled shortly after
  task automatic drive(input logic en, input logic pend, input logic rd, input logic nmi,
                       input logic irq, input logic bnd);
    @(negedge clk);
    enableFFs = en; pendingInterrupt = pend; resetDetected = rd;
    nmiGenerated = nmi; irqGenerated = irq; instructionBoundary = bnd;
    #1;
    dataIn = memRd(addressOut);
    #1;
  endtask

  int nWe, nSpd, nSet, nIst, nPcl, nBusy, nGated;
  logic done;
  logic [15:0] pcvAtLoad, vecAddr;
  logic [7:0]  pByte;
  logic [23:0] e;

  initial begin
    nrst = 1'b0;
    enableFFs = 1'b1; pendingInterrupt = 1'b1; resetDetected = 1'b0; nmiGenerated = 1'b1;
    irqGenerated = 1'b1; instructionBoundary = 1'b1;
    pcIn = 16'h1234; spIn = 8'hFD; statusIn = 8'h00; dataIn = 8'h55;

    // reset state, with enable and a pending request active
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst addressOut", 32'(addressOut), 32'h0);
    check("rst dataOut", 32'(dataOut), 32'h0);
    check("rst strobes", 32'(strobes()), 32'h0);
    check("rst pcLoadValue", 32'(pcLoadValue), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst state", 32'(debugState), 32'h0);
    enableFFs = 1'b0; pendingInterrupt = 1'b0; nmiGenerated = 1'b0; irqGenerated = 1'b0;
    instructionBoundary = 1'b0;
    nrst = 1'b1;

    // disabled request must not start
    addVec(6'b010011, 8'h00, 16'h1234, 8'hFD, 8'h00, 16'h0000, 8'h00, 5'b00000, 16'h0000, 1'b0);
    // IRQ: 12,34,20 to 01FD then vector FFFE/FFFF = 8000
    addVec(6'b110011, 8'h00, 16'h1234, 8'hFD, 8'h00, 16'h0000, 8'h00, 5'b00000, 16'h0000, 1'b0);
    addVec(6'b110010, 8'h00, 16'h1234, 8'hFD, 8'h00, 16'h1234, 8'h00, 5'b00000, 16'h0000, 1'b1);
    addVec(6'b110010, 8'h00, 16'h1234, 8'hFD, 8'h00, 16'h01FD, 8'h12, 5'b11000, 16'h0000, 1'b1);
    addVec(6'b110010, 8'h00, 16'h1234, 8'hFD, 8'h00, 16'h01FD, 8'h34, 5'b11000, 16'h0000, 1'b1);
    addVec(6'b110010, 8'h00, 16'h1234, 8'hFD, 8'h00, 16'h01FD, 8'h20, 5'b11000, 16'h0000, 1'b1);
    addVec(6'b110010, 8'h00, 16'h1234, 8'hFD, 8'h00, 16'hFFFE, 8'h00, 5'b00110, 16'h0000, 1'b1);
    addVec(6'b110010, 8'h80, 16'h1234, 8'hFD, 8'h00, 16'hFFFF, 8'h00, 5'b00000, 16'h0000, 1'b1);
    addVec(6'b110010, 8'h00, 16'h1234, 8'hFD, 8'h00, 16'h0000, 8'h00, 5'b00001, 16'h8000, 1'b1);
    addVec(6'b110010, 8'h00, 16'h1234, 8'hFD, 8'h00, 16'h0000, 8'h00, 5'b00000, 16'h8000, 1'b0);
    // NMI beats simultaneous IRQ: vector FFFA/FFFB, status FF pushed as EF
    addVec(6'b110111, 8'h00, 16'hABCD, 8'h80, 8'hFF, 16'h0000, 8'h00, 5'b00000, 16'h8000, 1'b0);
    addVec(6'b110110, 8'h00, 16'hABCD, 8'h80, 8'hFF, 16'hABCD, 8'h00, 5'b00000, 16'h8000, 1'b1);
    addVec(6'b110110, 8'h00, 16'hABCD, 8'h80, 8'hFF, 16'h0180, 8'hAB, 5'b11000, 16'h8000, 1'b1);
    addVec(6'b110110, 8'h00, 16'hABCD, 8'h80, 8'hFF, 16'h0180, 8'hCD, 5'b11000, 16'h8000, 1'b1);
    addVec(6'b110110, 8'h00, 16'hABCD, 8'h80, 8'hFF, 16'h0180, 8'hEF, 5'b11000, 16'h8000, 1'b1);
    addVec(6'b110110, 8'h34, 16'hABCD, 8'h80, 8'hFF, 16'hFFFA, 8'h00, 5'b00110, 16'h8000, 1'b1);
    addVec(6'b110110, 8'h12, 16'hABCD, 8'h80, 8'hFF, 16'hFFFB, 8'h00, 5'b00000, 16'h8034, 1'b1);
    addVec(6'b110110, 8'h00, 16'hABCD, 8'h80, 8'hFF, 16'h0000, 8'h00, 5'b00001, 16'h1234, 1'b1);
    // back-to-back reset source: no writes, three SP decrements, vector FFFC/FFFD
    addVec(6'b111001, 8'h00, 16'h5678, 8'h00, 8'h04, 16'h0000, 8'h00, 5'b00000, 16'h1234, 1'b0);
    addVec(6'b111000, 8'h00, 16'h5678, 8'h00, 8'h04, 16'h5678, 8'h00, 5'b00000, 16'h1234, 1'b1);
    addVec(6'b111000, 8'h00, 16'h5678, 8'h00, 8'h04, 16'h0100, 8'h56, 5'b01000, 16'h1234, 1'b1);
    addVec(6'b111000, 8'h00, 16'h5678, 8'h00, 8'h04, 16'h0100, 8'h78, 5'b01000, 16'h1234, 1'b1);
    addVec(6'b111000, 8'h00, 16'h5678, 8'h00, 8'h04, 16'h0100, 8'h24, 5'b01000, 16'h1234, 1'b1);
    addVec(6'b111000, 8'h00, 16'h5678, 8'h00, 8'h04, 16'hFFFC, 8'h00, 5'b00110, 16'h1234, 1'b1);
    addVec(6'b111000, 8'hE0, 16'h5678, 8'h00, 8'h04, 16'hFFFD, 8'h00, 5'b00000, 16'h1200, 1'b1);
    addVec(6'b111000, 8'h00, 16'h5678, 8'h00, 8'h04, 16'h0000, 8'h00, 5'b00001, 16'hE000, 1'b1);
    addVec(6'b100000, 8'h00, 16'h5678, 8'h00, 8'h04, 16'h0000, 8'h00, 5'b00000, 16'hE000, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      {enableFFs, pendingInterrupt, resetDetected, nmiGenerated, irqGenerated,
       instructionBoundary} = vecs[i].flags;
      dataIn = vecs[i].din; pcIn = vecs[i].pc; spIn = vecs[i].sp; statusIn = vecs[i].st;
      #1;
      check($sformatf("vec%0d addressOut", i), 32'(addressOut), 32'(vecs[i].eAddr));
      check($sformatf("vec%0d dataOut", i), 32'(dataOut), 32'(vecs[i].eDout));
      check($sformatf("vec%0d strobes", i), 32'(strobes()), 32'(vecs[i].eStr));
      check($sformatf("vec%0d pcLoadValue", i), 32'(pcLoadValue), 32'(vecs[i].ePcv));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].eBusy));
    end

    // IRQ with enable toggling every other cycle
    pcIn = 16'h1234; spIn = 8'hFD; statusIn = 8'h00;
    exp_q = {24'h01FD12, 24'h01FD34, 24'h01FD20};
    nWe = 0; nSpd = 0; nSet = 0; nIst = 0; nPcl = 0; nBusy = 0; nGated = 0;
    done = 1'b0; pcvAtLoad = 16'h0;
    for (int c = 0; c < 40 && !done; c++) begin
      drive((c % 2) == 0, 1'b1, 1'b0, 1'b0, 1'b1, c == 0);
      if (busy) nBusy++;
      else if (c > 0) done = 1'b1;
      if (!enableFFs && strobes() != 5'b0) nGated++;
      if (writeEn) begin
        nWe++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("gated write", 32'({addressOut, dataOut}), 32'(e));
        end
      end
      if (spDecrement) nSpd++;
      if (setIFlag) nSet++;
      if (interruptStarted) nIst++;
      if (pcLoad) begin nPcl++; pcvAtLoad = pcLoadValue; end
    end
    check("gated finished", 32'(done), 32'h1);
    check("gated busy cycles", 32'(nBusy), 32'd14);
    check("gated writeEn count", 32'(nWe), 32'd3);
    check("gated spDecrement count", 32'(nSpd), 32'd3);
    check("gated setIFlag count", 32'(nSet), 32'd1);
    check("gated interruptStarted count", 32'(nIst), 32'd1);
    check("gated pcLoad count", 32'(nPcl), 32'd1);
    check("gated pcLoadValue", 32'(pcvAtLoad), 32'h8000);
    check("gated strobes while disabled", 32'(nGated), 32'd0);
    check("gated writes outstanding", 32'(exp_q.size()), 32'd0);

    // IRQ with NMI arriving in PUSH_PCL
    nIst = 0; done = 1'b0; pcvAtLoad = 16'h0; vecAddr = 16'h0; pByte = 8'h00;
    for (int c = 0; c < 20 && !done; c++) begin
      drive(1'b1, 1'b1, 1'b0, c >= 3, 1'b1, c == 0);
      if (!busy && c > 0) done = 1'b1;
      if (c == 4) pByte = dataOut;
      if (interruptStarted) begin nIst++; vecAddr = addressOut; end
      if (pcLoad) pcvAtLoad = pcLoadValue;
    end
    check("late nmi finished", 32'(done), 32'h1);
    check("late nmi pushed P", 32'(pByte), 32'h20);
    check("late nmi interruptStarted count", 32'(nIst), 32'd1);
`ifdef INTERRUPT_HIJACK_EN
    check("late nmi vector", 32'(vecAddr), 32'hFFFA);
    check("late nmi pcLoadValue", 32'(pcvAtLoad), 32'h1234);
`else
    check("late nmi vector", 32'(vecAddr), 32'hFFFE);
    check("late nmi pcLoadValue", 32'(pcvAtLoad), 32'h8000);
`endif

    // reset asserted during PUSH_PCL aborts the sequence
    for (int c = 0; c < 3; c++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, c == 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("abort pre writeEn", 32'(writeEn), 32'h1);
    nrst = 1'b0;
    #1;
    check("abort addressOut", 32'(addressOut), 32'h0);
    check("abort dataOut", 32'(dataOut), 32'h0);
    check("abort strobes", 32'(strobes()), 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    check("abort state", 32'(debugState), 32'h0);
    check("abort pcLoadValue", 32'(pcLoadValue), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    nWe = 0; nBusy = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (writeEn) nWe++;
      if (busy) nBusy++;
    end
    check("abort later writes", 32'(nWe), 32'd0);
    check("abort later busy", 32'(nBusy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameters: none; the block SHALL be fixed at 16-bit address and 8-bit data.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 nrst  input  1  asynchronous active-low reset.
REQ-004 enableFFs  input  1  clock enable; state SHALL advance only when high.
REQ-005 pendingInterrupt  input  1  an interrupt is awaiting service.
REQ-006 resetDetected, nmiGenerated, irqGenerated  input  1 each  interrupt source flags.
REQ-007 instructionBoundary  input  1  high in the cycle where an opcode fetch would start.
REQ-008 pcIn  input  16  current program counter.
REQ-009 spIn  input  8  current stack pointer.
REQ-010 statusIn  input  8  current processor status register.
REQ-011 dataIn  input  8  read data bus.
REQ-012 addressOut  output  16  bus address during the sequence.
REQ-013 dataOut  output  8  write data.
REQ-014 writeEn  output  1  bus write strobe.
REQ-015 spDecrement  output  1  one-cycle request to decrement SP.
REQ-016 setIFlag  output  1  one-cycle request to set the I flag.
REQ-017 interruptStarted  output  1  one-cycle acknowledge back to the interrupt detector.
REQ-018 pcLoad  output  1  one-cycle strobe to load pcLoadValue into PC.
REQ-019 pcLoadValue  output  16  assembled vector.
REQ-020 busy  output  1  high while any state other than IDLE is held.

Function
REQ-021 FSM states SHALL be IDLE, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD; each advance consumes one enabled cycle.
REQ-022 IDLE->DUMMY SHALL occur when pendingInterrupt && instructionBoundary && enableFFs; otherwise IDLE holds.
REQ-023 Source SHALL be latched on leaving IDLE with priority resetDetected > nmiGenerated > irqGenerated; if none is set, the sequencer SHALL use IRQ.
REQ-024 DUMMY: addressOut=pcIn, writeEn=0.
REQ-025 PUSH_PCH / PUSH_PCL / PUSH_P: addressOut={8'h01,spIn}; dataOut=pcIn[15:8] / pcIn[7:0] / (statusIn with bit5=1, bit4=0); spDecrement=1.
REQ-026 For a reset source, the push states SHALL hold writeEn=0 while still asserting spDecrement; for other sources writeEn=1 in push states.
REQ-027 VEC_LO: addressOut = FFFC (reset), FFFA (NMI), FFFE (IRQ); dataIn captured as low byte; setIFlag=1 and interruptStarted=1 for exactly this cycle.
REQ-028 VEC_HI: addressOut = VEC_LO address + 1; dataIn captured as high byte.
REQ-029 LOAD: pcLoad=1 with pcLoadValue={high,low}; next state IDLE; busy falls the following cycle.
REQ-030 When enableFFs=0, state, latches and all strobes SHALL freeze, and strobes SHALL read 0.
REQ-031 New pendingInterrupt during busy SHALL be ignored until return to IDLE; back-to-back service SHALL be allowed directly from LOAD->IDLE->DUMMY.
REQ-032 writeEn, spDecrement, setIFlag, interruptStarted and pcLoad SHALL be 0 outside the states named above.

Reset
REQ-033 On nrst low: state=IDLE, latched source=IRQ, captured bytes=0, all outputs 0 (addressOut=0, dataOut=0), regardless of clk or enableFFs.
REQ-034 Reset mid-sequence SHALL abort without completing any remaining bus write.

Configuration
REQ-035 Macro INTERRUPT_HIJACK_EN: when defined, an IRQ sequence seeing nmiGenerated=1 in any state before VEC_LO SHALL switch the vector to FFFA/FFFB, and only one interruptStarted pulse SHALL occur; when undefined, the latched source SHALL be fixed for the whole sequence.

Verification
REQ-036 IRQ only, pcIn=1234, spIn=FD, statusIn=00 -> writes 12@01FD, 34@01FD, 20@01FD across three cycles; reads FFFE=00, FFFF=80; pcLoadValue=8000; one interruptStarted.
REQ-037 NMI with IRQ simultaneous -> vector FFFA/FFFB used, IRQ not serviced in that sequence.
REQ-038 resetDetected -> zero writeEn cycles, three spDecrement pulses, vector FFFC/FFFD loaded.
REQ-039 enableFFs toggled low every other cycle during IRQ -> identical bus sequence, twice the duration, no duplicated strobes.
REQ-040 With INTERRUPT_HIJACK_EN, NMI raised in PUSH_PCL of an IRQ -> pushed P has bit4=0 and vector FFFA is loaded; without the macro, vector FFFE is loaded.
REQ-041 nrst asserted in PUSH_PCL -> outputs 0 immediately, state IDLE, no further writes.
